// File: rtl/hint_bit_unpack_if.sv
// rtl/hint_bit_unpack_if.sv - start/result bundle of the ML-DSA hint bit unpacker
//
// Purpose: groups the request side (startpin, y) and the result side
// (endpin, fail, h, optional ones_count) of hint_bit_unpack.
// Signals:
//   startpin    start request, level
//   y           packed hint bytes y[0..W+K-1], held stable by the driver
//   endpin      done
//   fail        malformed encoding, valid while endpin=1
//   h           K x 256 hint bit matrix, valid while endpin=1
//   ones_count  total hint count (only with HBU_ONES_COUNT_EN)
// Modports: master drives the request, slave is the unpacker.
// Optional feature macro: HBU_ONES_COUNT_EN.

interface hint_bit_unpack_if #(
  parameter int K = 8,
  parameter int W = 75
);
  logic                     startpin;
  logic [W+K-1:0][7:0]      y;
  logic                     endpin;
  logic                     fail;
  logic [K-1:0][255:0]      h;
`ifdef HBU_ONES_COUNT_EN
  logic [7:0]               ones_count;

  modport master (output startpin, y, input endpin, fail, h, ones_count);
  modport slave  (input startpin, y, output endpin, fail, h, ones_count);
`else
  modport master (output startpin, y, input endpin, fail, h);
  modport slave  (input startpin, y, output endpin, fail, h);
`endif
endinterface

// File: rtl/hint_bit_unpack.sv
// rtl/hint_bit_unpack.sv - ML-DSA HintBitUnpack with malformed-encoding detection
//
// Purpose: rebuilds the K x 256 hint matrix h from the packed byte string
// y[W+K] (positions in y[0..W-1], cumulative row counts in y[W..W+K-1]) and
// flags encodings that a conforming packer could not have produced.
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   hint_bit_unpack_if.slave (startpin, y in; endpin, fail, h out)
// Optional feature macro: HBU_ONES_COUNT_EN adds bus.ones_count, the total
// hint count on success (0 on fail).
// Timing: a successful decode raises endpin after edge K+W+2, counting the
// edge that samples startpin as edge 0, regardless of hint count.

module hint_bit_unpack #(
  parameter int K = 8,
  parameter int W = 75
) (
  input  logic            clk,
  input  logic            rst,
  hint_bit_unpack_if.slave bus
);

  localparam int RW  = $clog2(K) + 1;
  localparam int RSW = (K > 1) ? $clog2(K) : 1;
  localparam int YIW = $clog2(W + K);
  localparam logic [7:0] W8 = 8'(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LIMIT,
    S_UNPACK,
    S_ZERO,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          idx_q, idx_d;
  logic [RW-1:0]       row_q, row_d;
  logic [7:0]          first_q, first_d;
  logic [7:0]          lim_q, lim_d;
  logic                endpin_q, endpin_d;
  logic                fail_q, fail_d;
  logic [K-1:0][255:0] h_q, h_d;
`ifdef HBU_ONES_COUNT_EN
  logic [7:0]          cnt_q, cnt_d;
`endif

  // Byte selects into y, narrowed to the width of the y index space.
  logic [YIW-1:0] yi_idx, yi_prev, yi_lim;
  logic [7:0]     pos_cur, pos_prev, lim_now;
  logic [RSW-1:0] row_sel;
  logic           last_row;

  assign yi_idx   = YIW'(idx_q);
  assign yi_prev  = YIW'(idx_q - 8'd1);
  assign yi_lim   = YIW'(W) + YIW'(row_q);
  assign pos_cur  = bus.y[yi_idx];
  assign pos_prev = bus.y[yi_prev];
  assign lim_now  = bus.y[yi_lim];
  assign row_sel  = RSW'(row_q);
  assign last_row = (row_q == RW'(K - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      row_q    <= '0;
      first_q  <= '0;
      lim_q    <= '0;
      endpin_q <= 1'b0;
      fail_q   <= 1'b0;
      h_q      <= '0;
`ifdef HBU_ONES_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      first_q  <= first_d;
      lim_q    <= lim_d;
      endpin_q <= endpin_d;
      fail_q   <= fail_d;
      h_q      <= h_d;
`ifdef HBU_ONES_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    row_d    = row_q;
    first_d  = first_q;
    lim_d    = lim_q;
    endpin_d = endpin_q;
    fail_d   = fail_q;
    h_d      = h_q;
`ifdef HBU_ONES_COUNT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.startpin) begin
          h_d      = '0;
          fail_d   = 1'b0;
          endpin_d = 1'b0;
          idx_d    = '0;
          row_d    = '0;
`ifdef HBU_ONES_COUNT_EN
          cnt_d    = '0;
`endif
          state_d  = S_LIMIT;
        end
      end

      S_LIMIT: begin
        lim_d = lim_now;
        // Cumulative counts must be non-decreasing and never exceed W.
        if ((lim_now < idx_q) || (lim_now > W8)) begin
          fail_d  = 1'b1;
          h_d     = '0;
`ifdef HBU_ONES_COUNT_EN
          cnt_d   = '0;
`endif
          state_d = S_DONE;
        end else if (lim_now == idx_q) begin
          if (last_row) begin
            state_d = S_ZERO;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          first_d = idx_q;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        // Inside one row positions must strictly increase; the first
        // position of a row is not compared with the previous row.
        if ((idx_q > first_q) && (pos_prev >= pos_cur)) begin
          fail_d  = 1'b1;
          h_d     = '0;
`ifdef HBU_ONES_COUNT_EN
          cnt_d   = '0;
`endif
          state_d = S_DONE;
        end else begin
          h_d[row_sel][pos_cur] = 1'b1;
          idx_d = idx_q + 8'd1;
`ifdef HBU_ONES_COUNT_EN
          cnt_d = cnt_q + 8'd1;
`endif
          if ((idx_q + 8'd1) == lim_q) begin
            if (last_row) begin
              state_d = S_ZERO;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = S_LIMIT;
            end
          end
        end
      end

      S_ZERO: begin
        // Unused position bytes must be zero padding.
        if (idx_q == W8) begin
          state_d = S_DONE;
        end else if (pos_cur != 8'd0) begin
          fail_d  = 1'b1;
          h_d     = '0;
`ifdef HBU_ONES_COUNT_EN
          cnt_d   = '0;
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end

      S_DONE: begin
        // endpin is held high for at least one cycle so a requester that
        // has already dropped startpin still sees the result.
        endpin_d = 1'b1;
        if (endpin_q && !bus.startpin) begin
          endpin_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.endpin = endpin_q;
  assign bus.fail   = fail_q;
  assign bus.h      = h_q;
`ifdef HBU_ONES_COUNT_EN
  assign bus.ones_count = cnt_q;
`endif

endmodule
